guess_sequencer: RTL and testbench
==================================

# guess_sequencer

Front-end sequencer for the three-digit A/B guessing game. Collects decoded keypad digits, validates each entry, and issues one-cycle number-ready pulses to the game display datapath: the first accepted entry is the answer, and later entries are guesses. Counts attempts, detects win (three hits) or loss (attempt limit), and pulses a clear to restart the datapath. Sits between the keypad decoder and the game/display block, in the same clock domain.

## Interface
- MAX_TRIES, 10, number of guesses allowed before loss (1..15)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- key_valid  in  1  one-cycle strobe; key_code valid this cycle
- key_code  in  4  0x0-0x9 digit, 0xA clear, 0xB enter; 0xC-0xF ignored
- hit_cnt  in  2  datapath "A" count; sampled only in the cycle oNumRdy=1
- oNum1, oNum2, oNum3  out  4 each  entry registers, most significant digit first
- oNumRdy  out  1  one-cycle pulse; oNum1..3 are valid and stable
- digit_cnt  out  2  digits entered so far (0..3)
- phase  out  2  0 = answer entry, 1 = guessing, 2 = won, 3 = lost
- tries  out  4  guesses issued since the answer was set
- err  out  1  one-cycle pulse when an entry is rejected
- game_clr  out  1  one-cycle pulse to clear the downstream datapath

## Operation
- States: ENTRY, ISSUE, WIN, LOSE. Reset puts the block in ENTRY with phase=0.
- All outputs are 0 after reset.
- ENTRY, digit key:
  - digit_cnt=0: oNum1 takes the digit, oNum2 and oNum3 go to 0, digit_cnt=1.
  - digit_cnt=1: oNum2 takes the digit. digit_cnt=2: oNum3 takes the digit.
  - digit_cnt=3: the key is ignored.
- ENTRY, clear key: digit_cnt=0. oNum values are kept.
- ENTRY, enter key: the entry is accepted if digit_cnt==3 and the digits pass the distinctness check (see Configuration). Accepted → ISSUE. Otherwise err pulses, digit_cnt=0, and the state stays ENTRY.
- ISSUE (one cycle): oNumRdy=1 and digit_cnt=0.
  - phase 0: phase becomes 1, tries stays 0, next state ENTRY.
  - phase 1: tries = tries+1.
    - hit_cnt==3 → WIN (phase 2).
    - else tries+1==MAX_TRIES → LOSE (phase 3).
    - else → ENTRY.
    - If hit_cnt==3 and the limit is reached in the same cycle, WIN takes priority.
- WIN/LOSE: digit and enter keys are ignored. A clear key pulses game_clr and returns the block to ENTRY with phase=0, tries=0, digit_cnt=0 and oNum1..3=0.
- tries saturates at 15. It never wraps.
- Keys arriving during ISSUE are dropped. They are not queued.

## Timing
- A key strobed at edge N is reflected in the registered outputs after edge N.
- Enter accepted at edge N → oNumRdy is high for the cycle after edge N.
  - hit_cnt is sampled at edge N+1.
  - phase, tries and the WIN/LOSE transition are visible after edge N+1.
- err is high for exactly the one cycle after the rejecting edge.
- game_clr is high for exactly the one cycle after the clear edge.
- oNum1..3 are unchanged from the accepting edge until the next digit key.
- Reset asserted in any state, including ISSUE, wins over all key activity.
  - Everything returns to reset values at that edge.
  - No oNumRdy or err pulse is produced for the aborted entry.
- Throughput: at most one issue per 2 cycles.

## Configuration
- GUESS_DISTINCT_CHK_EN defined:
  - Enter is rejected (err pulse) if any two of oNum1..3 are equal.
  - This applies to both the answer and guesses.
- GUESS_DISTINCT_CHK_EN undefined:
  - Any complete 3-digit entry is accepted.
  - No comparators are built.

## Test plan
- Reset, then keys 1,2,3,enter → oNum=1/2/3, oNumRdy pulse one cycle after enter, phase 0→1, tries stays 0.
- Answer 123, guess 4,5,6,enter with hit_cnt=0 → oNumRdy pulse, tries=1, phase=1. Then guess 1,2,3,enter with hit_cnt=3 → tries=2, phase=2. Further digits are ignored.
- MAX_TRIES=2, answer set, two guesses with hit_cnt=1 → phase=3 after the second issue. Then clear → game_clr single pulse, phase=0, tries=0, oNum=0.
- Keys 7,enter → err pulse, no oNumRdy, digit_cnt=0. With the macro defined, 5,5,1,enter → err. Without the macro, the same sequence produces oNumRdy.
- Keys 1,2,3,4 → oNum=1/2/3, digit_cnt=3. Then clear, 9,8,7,enter → oNum=9/8/7 issued.
- Reset asserted in the ISSUE cycle → no further pulses, all outputs 0 the next cycle. A key_valid during ISSUE is dropped.

Source files
------------

// File: rtl/guess_sequencer.sv
// Keypad entry sequencer for the three-digit A/B guessing game: collects digits, issues the
// answer then guesses, and tracks win/loss. Optional GUESS_DISTINCT_CHK_EN rejects repeated digits.
module guess_sequencer #(
  parameter int unsigned MAX_TRIES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [1:0] hit_cnt,
  output logic [3:0] oNum1,
  output logic [3:0] oNum2,
  output logic [3:0] oNum3,
  output logic       oNumRdy,
  output logic [1:0] digit_cnt,
  output logic [1:0] phase,
  output logic [3:0] tries,
  output logic       err,
  output logic       game_clr
);

  typedef enum logic [1:0] {StEntry, StIssue, StWin, StLose} state_e;

  localparam logic [3:0] KeyClear = 4'hA;
  localparam logic [3:0] KeyEnter = 4'hB;
  localparam logic [4:0] MaxTries = 5'(MAX_TRIES);

  state_e     state_q, state_d;
  logic [3:0] num1_q, num1_d, num2_q, num2_d, num3_q, num3_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] tries_q, tries_d;
  logic       err_q, err_d;
  logic       clr_q, clr_d;
  logic       entry_ok;
  logic [4:0] tries_plus;
  logic [3:0] tries_sat;

`ifdef GUESS_DISTINCT_CHK_EN
  assign entry_ok = (cnt_q == 2'd3) && (num1_q != num2_q) && (num1_q != num3_q) &&
                    (num2_q != num3_q);
`else
  assign entry_ok = (cnt_q == 2'd3);
`endif

  // Limit test uses the unsaturated increment; the stored count saturates at 15.
  assign tries_plus = {1'b0, tries_q} + 5'd1;
  assign tries_sat  = (tries_q == 4'hF) ? 4'hF : tries_plus[3:0];

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    num3_d  = num3_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    tries_d = tries_q;
    err_d   = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      StEntry: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            unique case (cnt_q)
              2'd0: begin
                num1_d = key_code;
                num2_d = 4'd0;
                num3_d = 4'd0;
                cnt_d  = 2'd1;
              end
              2'd1: begin
                num2_d = key_code;
                cnt_d  = 2'd2;
              end
              2'd2: begin
                num3_d = key_code;
                cnt_d  = 2'd3;
              end
              default: ;
            endcase
          end else if (key_code == KeyClear) begin
            cnt_d = 2'd0;
          end else if (key_code == KeyEnter) begin
            cnt_d = 2'd0;
            if (entry_ok) state_d = StIssue;
            else          err_d   = 1'b1;
          end
        end
      end
      StIssue: begin
        cnt_d = 2'd0;
        if (phase_q == 2'd0) begin
          phase_d = 2'd1;
          state_d = StEntry;
        end else begin
          tries_d = tries_sat;
          if (hit_cnt == 2'd3) begin
            phase_d = 2'd2;
            state_d = StWin;
          end else if (tries_plus == MaxTries) begin
            phase_d = 2'd3;
            state_d = StLose;
          end else begin
            state_d = StEntry;
          end
        end
      end
      StWin, StLose: begin
        if (key_valid && key_code == KeyClear) begin
          clr_d   = 1'b1;
          state_d = StEntry;
          phase_d = 2'd0;
          tries_d = 4'd0;
          cnt_d   = 2'd0;
          num1_d  = 4'd0;
          num2_d  = 4'd0;
          num3_d  = 4'd0;
        end
      end
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEntry;
      num1_q  <= 4'd0;
      num2_q  <= 4'd0;
      num3_q  <= 4'd0;
      cnt_q   <= 2'd0;
      phase_q <= 2'd0;
      tries_q <= 4'd0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      num3_q  <= num3_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tries_q <= tries_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
    end
  end

  assign oNum1     = num1_q;
  assign oNum2     = num2_q;
  assign oNum3     = num3_q;
  assign oNumRdy   = (state_q == StIssue);
  assign digit_cnt = cnt_q;
  assign phase     = phase_q;
  assign tries     = tries_q;
  assign err       = err_q;
  assign game_clr  = clr_q;

endmodule

// File: tb/tb_guess_sequencer.sv
// Self-checking bench for guess_sequencer: directed scenarios plus random key traffic
// checked against a key-level model of the game rules.
module tb_guess_sequencer;

  localparam int unsigned MAX = 2;
`ifdef GUESS_DISTINCT_CHK_EN
  localparam bit DIST = 1'b1;
`else
  localparam bit DIST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] hit_cnt;
  logic [3:0] oNum1, oNum2, oNum3;
  logic       oNumRdy;
  logic [1:0] digit_cnt;
  logic [1:0] phase;
  logic [3:0] tries;
  logic       err;
  logic       game_clr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_nums[3];
  int m_cnt, m_phase, m_tries;
  bit m_issue, m_err, m_clr;

  guess_sequencer #(.MAX_TRIES(MAX)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code), .hit_cnt(hit_cnt),
    .oNum1(oNum1), .oNum2(oNum2), .oNum3(oNum3), .oNumRdy(oNumRdy), .digit_cnt(digit_cnt),
    .phase(phase), .tries(tries), .err(err), .game_clr(game_clr)
  );

  always #5 clk = ~clk;

  task automatic model_zero();
    m_nums = '{0, 0, 0};
    m_cnt = 0; m_phase = 0; m_tries = 0;
    m_issue = 0; m_err = 0; m_clr = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; key_valid = 1'b0; key_code = 4'd0; hit_cnt = 2'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_zero();
  endtask

  // One clock of stimulus; the model advances by the game rules. Called and returns at negedge.
  task automatic cycle(input bit kv, input int kc, input int hc);
    bit ok;
    key_valid = kv; key_code = 4'(kc); hit_cnt = 2'(hc);
    m_err = 0; m_clr = 0;
    if (m_issue) begin
      m_issue = 0;
      if (m_phase == 0) m_phase = 1;
      else begin
        if (hc == 3) m_phase = 2;
        else if (m_tries + 1 == MAX) m_phase = 3;
        m_tries = (m_tries < 15) ? m_tries + 1 : 15;
      end
    end else if (kv) begin
      if (m_phase >= 2) begin
        if (kc == 10) begin
          model_zero();
          m_clr = 1;
        end
      end else if (kc <= 9) begin
        if (m_cnt < 3) begin
          if (m_cnt == 0) m_nums = '{0, 0, 0};
          m_nums[m_cnt] = kc;
          m_cnt++;
        end
      end else if (kc == 10) begin
        m_cnt = 0;
      end else if (kc == 11) begin
        ok = (m_cnt == 3) && (!DIST || (m_nums[0] != m_nums[1] && m_nums[0] != m_nums[2] &&
                                        m_nums[1] != m_nums[2]));
        m_cnt = 0;
        if (ok) m_issue = 1;
        else    m_err = 1;
      end
    end
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press(input int kc, input int hc = 0);
    cycle(1'b1, kc, hc);
  endtask

  task automatic test_reset();
    press(1); press(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_zero();
    checks++;
    if ({oNum1, oNum2, oNum3, oNumRdy, digit_cnt, phase, tries, err, game_clr} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h %h rdy=%b cnt=%0d ph=%0d tr=%0d err=%b clr=%b, want all 0",
               oNum1, oNum2, oNum3, oNumRdy, digit_cnt, phase, tries, err, game_clr);
    end
  endtask

  task automatic test_answer();
    apply_reset();
    press(1); press(2); press(3);
    checks++;
    if (digit_cnt !== 2'd3) begin
      errors++; $display("FAIL answer_cnt: got %0d want 3", digit_cnt);
    end
    press(11);
    checks++;
    if (oNumRdy !== 1'b1 || {oNum1, oNum2, oNum3} !== 12'h123 || phase !== 2'd0) begin
      errors++;
      $display("FAIL answer_issue: rdy=%b num=%h%h%h ph=%0d want rdy=1 num=123 ph=0",
               oNumRdy, oNum1, oNum2, oNum3, phase);
    end
    cycle(0, 0, 0);
    checks++;
    if (phase !== 2'd1 || tries !== 4'd0 || oNumRdy !== 1'b0) begin
      errors++;
      $display("FAIL answer_phase: ph=%0d tr=%0d rdy=%b want ph=1 tr=0 rdy=0", phase, tries, oNumRdy);
    end
  endtask

  task automatic test_win();
    apply_reset();
    press(1); press(2); press(3); press(11); cycle(0, 0, 0);
    press(4); press(5); press(6); press(11);
    checks++;
    if (oNumRdy !== 1'b1 || {oNum1, oNum2, oNum3} !== 12'h456) begin
      errors++;
      $display("FAIL guess_issue: rdy=%b num=%h%h%h want rdy=1 num=456", oNumRdy, oNum1, oNum2, oNum3);
    end
    cycle(0, 0, 0);
    checks++;
    if (tries !== 4'd1 || phase !== 2'd1) begin
      errors++; $display("FAIL guess_miss: tr=%0d ph=%0d want tr=1 ph=1", tries, phase);
    end
    // Second guess also reaches the limit: win must take priority
    press(1); press(2); press(3); press(11); cycle(0, 0, 3);
    checks++;
    if (tries !== 4'd2 || phase !== 2'd2) begin
      errors++; $display("FAIL guess_win: tr=%0d ph=%0d want tr=2 ph=2", tries, phase);
    end
    press(7); press(11);
    checks++;
    if (digit_cnt !== 2'd0 || {oNum1, oNum2, oNum3} !== 12'h123 || oNumRdy !== 1'b0 ||
        err !== 1'b0) begin
      errors++;
      $display("FAIL win_ignore: cnt=%0d num=%h%h%h rdy=%b err=%b want cnt=0 num=123 rdy=0 err=0",
               digit_cnt, oNum1, oNum2, oNum3, oNumRdy, err);
    end
  endtask

  task automatic test_lose();
    apply_reset();
    press(1); press(2); press(3); press(11); cycle(0, 0, 0);
    press(4); press(5); press(6); press(11); cycle(0, 0, 1);
    press(7); press(8); press(9); press(11); cycle(0, 0, 1);
    checks++;
    if (phase !== 2'd3 || tries !== 4'd2) begin
      errors++; $display("FAIL lose_phase: ph=%0d tr=%0d want ph=3 tr=2", phase, tries);
    end
    press(10);
    checks++;
    if (game_clr !== 1'b1 || phase !== 2'd0 || tries !== 4'd0 ||
        {oNum1, oNum2, oNum3} !== 12'h000) begin
      errors++;
      $display("FAIL lose_clear: clr=%b ph=%0d tr=%0d num=%h%h%h want clr=1 ph=0 tr=0 num=000",
               game_clr, phase, tries, oNum1, oNum2, oNum3);
    end
    cycle(0, 0, 0);
    checks++;
    if (game_clr !== 1'b0) begin
      errors++; $display("FAIL clear_pulse: clr=%b want 0", game_clr);
    end
  endtask

  task automatic test_reject();
    apply_reset();
    press(7); press(11);
    checks++;
    if (err !== 1'b1 || oNumRdy !== 1'b0 || digit_cnt !== 2'd0) begin
      errors++;
      $display("FAIL short_entry: err=%b rdy=%b cnt=%0d want err=1 rdy=0 cnt=0", err, oNumRdy, digit_cnt);
    end
    cycle(0, 0, 0);
    checks++;
    if (err !== 1'b0 || oNumRdy !== 1'b0) begin
      errors++; $display("FAIL err_pulse: err=%b rdy=%b want err=0 rdy=0", err, oNumRdy);
    end
    press(5); press(5); press(1); press(11);
    checks++;
    if (err !== DIST || oNumRdy !== !DIST) begin
      errors++;
      $display("FAIL repeat_digits: err=%b rdy=%b want err=%b rdy=%b", err, oNumRdy, DIST, !DIST);
    end
  endtask

  task automatic test_overflow_clear();
    apply_reset();
    press(1); press(2); press(3); press(4);
    checks++;
    if ({oNum1, oNum2, oNum3} !== 12'h123 || digit_cnt !== 2'd3) begin
      errors++;
      $display("FAIL fourth_digit: num=%h%h%h cnt=%0d want num=123 cnt=3", oNum1, oNum2, oNum3, digit_cnt);
    end
    press(10);
    checks++;
    if (digit_cnt !== 2'd0 || {oNum1, oNum2, oNum3} !== 12'h123) begin
      errors++;
      $display("FAIL entry_clear: cnt=%0d num=%h%h%h want cnt=0 num=123", digit_cnt, oNum1, oNum2, oNum3);
    end
    press(9); press(8); press(7); press(11);
    checks++;
    if (oNumRdy !== 1'b1 || {oNum1, oNum2, oNum3} !== 12'h987) begin
      errors++;
      $display("FAIL reentry_issue: rdy=%b num=%h%h%h want rdy=1 num=987", oNumRdy, oNum1, oNum2, oNum3);
    end
  endtask

  task automatic test_issue_abort();
    apply_reset();
    press(1); press(2); press(3); press(11);
    checks++;
    if (oNumRdy !== 1'b1) begin
      errors++; $display("FAIL abort_setup: rdy=%b want 1", oNumRdy);
    end
    reset = 1'b1; key_valid = 1'b1; key_code = 4'd5; hit_cnt = 2'd3;
    @(negedge clk);
    reset = 1'b0; key_valid = 1'b0;
    model_zero();
    checks++;
    if ({oNum1, oNum2, oNum3, oNumRdy, digit_cnt, phase, tries, err, game_clr} !== 25'd0) begin
      errors++;
      $display("FAIL abort_reset: num=%h%h%h rdy=%b cnt=%0d ph=%0d tr=%0d err=%b clr=%b want all 0",
               oNum1, oNum2, oNum3, oNumRdy, digit_cnt, phase, tries, err, game_clr);
    end
    cycle(0, 0, 0);
    checks++;
    if (oNumRdy !== 1'b0 || err !== 1'b0 || phase !== 2'd0) begin
      errors++; $display("FAIL abort_quiet: rdy=%b err=%b ph=%0d want 0 0 0", oNumRdy, err, phase);
    end
    // Key during ISSUE is dropped
    press(1); press(2); press(3); press(11); press(7);
    checks++;
    if (digit_cnt !== 2'd0 || {oNum1, oNum2, oNum3} !== 12'h123 || phase !== 2'd1) begin
      errors++;
      $display("FAIL issue_drop: cnt=%0d num=%h%h%h ph=%0d want cnt=0 num=123 ph=1",
               digit_cnt, oNum1, oNum2, oNum3, phase);
    end
  endtask

  task automatic test_random();
    int r, kc;
    logic [24:0] exp_v;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 12)      kc = r % 10;
      else if (r < 15) kc = 11;
      else if (r < 17) kc = 10;
      else             kc = 12 + (r % 4);
      cycle(($urandom_range(0, 9) < 7), kc, int'($urandom_range(0, 3)));
      exp_v = {4'(m_nums[0]), 4'(m_nums[1]), 4'(m_nums[2]), m_issue, 2'(m_cnt), 2'(m_phase),
               4'(m_tries), m_err, m_clr};
      checks++;
      if ({oNum1, oNum2, oNum3, oNumRdy, digit_cnt, phase, tries, err, game_clr} !== exp_v) begin
        errors++;
        $display("FAIL random_cycle %0d: got num=%h%h%h rdy=%b cnt=%0d ph=%0d tr=%0d err=%b clr=%b, want %h",
                 i, oNum1, oNum2, oNum3, oNumRdy, digit_cnt, phase, tries, err, game_clr, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 4'd0; hit_cnt = 2'd0;
    model_zero();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_answer();
    test_win();
    test_lose();
    test_reject();
    test_overflow_clear();
    test_issue_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
